// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: initiator side of the multi-cycle multiplier interface.
//
// Accepts one ALU or MULT op per cycle over valid/ready, starts the external 4-cycle
// multiplier, tracks the pending MULT tag, and merges 2-cycle ALU results and 4-cycle
// MULT results onto one registered writeback port. A sticky proto_err flags any
// disagreement between the local multiplier mirror and the multiplier's own strobes.
//
// Ports:
//   clock, reset                    single clock, synchronous active-high reset
//   issue_valid/ready/is_mult/rd    issue handshake and op descriptor
//   issue_operand_A/B, alu_result   MULT operands / precomputed ALU result
//   mult_select, mult_operand_A/B   start pulse and operands to the multiplier
//   mult_result, mult_ready         multiplier product and its result-cycle strobe
//   mult_stall_alu, mult_stall_mult multiplier collision / busy indications
//   wb_valid, wb_rd, wb_data        registered writeback port
//   proto_err                       sticky protocol-mismatch flag
//
// Optional feature macro: MULT_ISSUE_PERF_EN adds perf_alu_cnt, perf_mult_cnt and
// perf_stall_cnt (32-bit wrapping counters of ALU accepts, MULT accepts and stalled
// cycles once the post-reset drain is over).
module mult_issue_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_BITS   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  issue_is_mult,
  input  logic [REG_BITS-1:0]   issue_rd,
  input  logic [DATA_WIDTH-1:0] issue_operand_A,
  input  logic [DATA_WIDTH-1:0] issue_operand_B,
  input  logic [DATA_WIDTH-1:0] issue_alu_result,
  output logic                  mult_select,
  output logic [DATA_WIDTH-1:0] mult_operand_A,
  output logic [DATA_WIDTH-1:0] mult_operand_B,
  input  logic [DATA_WIDTH-1:0] mult_result,
  input  logic                  mult_ready,
  input  logic                  mult_stall_alu,
  input  logic                  mult_stall_mult,
  output logic                  wb_valid,
  output logic [REG_BITS-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  proto_err
`ifdef MULT_ISSUE_PERF_EN
  ,
  output logic [31:0]           perf_alu_cnt,
  output logic [31:0]           perf_mult_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  logic [1:0]            drain_q;
  logic [1:0]            mcnt_q;
  logic [REG_BITS-1:0]   mtag_q;
  logic                  stage_valid_q;
  logic [REG_BITS-1:0]   stage_rd_q;
  logic [DATA_WIDTH-1:0] stage_data_q;
  logic                  wb_valid_q;
  logic [REG_BITS-1:0]   wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic                  proto_err_q;

  logic drain_done;
  logic accept;
  logic mult_accept;
  logic alu_accept;
  logic mult_capture;
  logic err_now;

  always_comb begin
    drain_done   = (drain_q == 2'd0);
    issue_ready  = !reset && drain_done &&
                   (issue_is_mult ? (mcnt_q == 2'd0) : !mult_stall_alu);
    accept       = issue_valid && issue_ready;
    mult_accept  = accept && issue_is_mult;
    alu_accept   = accept && !issue_is_mult;
    mult_select  = mult_accept;
    mult_capture = mult_ready && (mcnt_q == 2'd3);
    // Checks are masked while draining: the multiplier keeps no reset and may still
    // emit strobes for an op that was in flight when reset hit.
    err_now      = (drain_done &&
                    ((mult_ready != (mcnt_q == 2'd3)) ||
                     (mult_stall_mult && !mult_select && (mcnt_q != 2'd1)))) ||
                   (mult_capture && stage_valid_q);
  end

  assign mult_operand_A = issue_operand_A;
  assign mult_operand_B = issue_operand_B;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign proto_err      = proto_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      drain_q       <= 2'd3;
      mcnt_q        <= 2'd0;
      mtag_q        <= '0;
      stage_valid_q <= 1'b0;
      stage_rd_q    <= '0;
      stage_data_q  <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      if (!drain_done) begin
        drain_q <= drain_q - 2'd1;
      end

      // mcnt mirrors the multiplier pipeline: 1..3 while a product is in flight.
      if (mult_accept) begin
        mcnt_q <= 2'd1;
        mtag_q <= issue_rd;
      end else if (mcnt_q != 2'd0) begin
        mcnt_q <= mcnt_q + 2'd1;
      end

      stage_valid_q <= alu_accept;
      if (alu_accept) begin
        stage_rd_q   <= issue_rd;
        stage_data_q <= issue_alu_result;
      end

      // MULT result wins any same-cycle conflict; the lost ALU result raises proto_err.
      if (mult_capture) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= mtag_q;
        wb_data_q  <= mult_result;
      end else begin
        wb_valid_q <= stage_valid_q;
        if (stage_valid_q) begin
          wb_rd_q   <= stage_rd_q;
          wb_data_q <= stage_data_q;
        end
      end

      if (err_now) begin
        proto_err_q <= 1'b1;
      end
    end
  end

`ifdef MULT_ISSUE_PERF_EN
  logic [31:0] perf_alu_q;
  logic [31:0] perf_mult_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_alu_q   <= '0;
      perf_mult_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (alu_accept)  perf_alu_q  <= perf_alu_q + 32'd1;
      if (mult_accept) perf_mult_q <= perf_mult_q + 32'd1;
      if (issue_valid && !issue_ready && drain_done) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_alu_cnt   = perf_alu_q;
  assign perf_mult_cnt  = perf_mult_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
